bram_portb_arbiter: RTL and testbench

Shares BRAM port b between the VGA scan-out reader and a keyboard-side writer that deposits scancodes and characters into video/text memory. VGA reads have priority. Keyboard writes are buffered in a small internal FIFO and drained into free slots. A starvation limit guarantees that buffered writes always make progress. Sits between vgaControl, ps2_keyboard glue logic and the port-b side of bram.

---
 rtl/bram_portb_arbiter_if.sv | 44 ++++
 rtl/bram_portb_arbiter.sv | 149 ++++++++++++++
 tb/tb_bram_portb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_portb_arbiter_if.sv
// ============================================================================
// Module  : bram_portb_arbiter_if
// Brief   : Bundle of VGA read, keyboard write and BRAM port-b signals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bram_portb_arbiter_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  vga_gnt;
    logic [WIDTH-1:0]      vga_rdata;
    logic                  vga_rvalid;
    logic                  kb_wr_valid;
    logic [ADDR_WIDTH-1:0] kb_wr_addr;
    logic [WIDTH-1:0]      kb_wr_data;
    logic                  kb_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [WIDTH-1:0]      mem_data_b;
    logic                  mem_we_b;
    logic [WIDTH-1:0]      mem_q_b;
    logic [c_CNT_W-1:0]    fifo_count;
    logic                  overflow;

    modport slave (
        input  vga_req, vga_addr, kb_wr_valid, kb_wr_addr, kb_wr_data, mem_q_b,
        output vga_gnt, vga_rdata, vga_rvalid, kb_wr_ready,
               mem_addr_b, mem_data_b, mem_we_b, fifo_count, overflow
    );

    modport master (
        output vga_req, vga_addr, kb_wr_valid, kb_wr_addr, kb_wr_data, mem_q_b,
        input  vga_gnt, vga_rdata, vga_rvalid, kb_wr_ready,
               mem_addr_b, mem_data_b, mem_we_b, fifo_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/bram_portb_arbiter.sv
// ============================================================================
// Module  : bram_portb_arbiter
// Brief   : BRAM port-b arbiter: VGA reads first, buffered keyboard writes
//           drained into free slots with a starvation guarantee.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bram_portb_arbiter #(
    parameter int WIDTH        = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input wire                 clk,
    input wire                 rst_n,
    bram_portb_arbiter_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_LIMIT);

    localparam logic [1:0] c_SLOT_IDLE = 2'd0;
    localparam logic [1:0] c_SLOT_VGA  = 2'd1;
    localparam logic [1:0] c_SLOT_KB   = 2'd2;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [WIDTH-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_STV_W-1:0]    r_starve;
    logic                  r_ready;
    logic                  r_overflow;
    logic                  r_gnt;
    logic                  r_rvalid;
    logic [WIDTH-1:0]      r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_data;
    logic                  r_we;

    logic                  w_empty;
    logic                  w_force;
    logic [1:0]            w_slot;
    logic                  w_push;
    logic                  w_pop;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic [c_STV_W-1:0]    w_starve_nxt;

    always_comb begin
        w_empty = (r_count == '0);
        w_force = !w_empty && (r_starve == c_STARVE_MAX);

        w_slot = c_SLOT_IDLE;
        if (!w_empty && (!bus.vga_req || w_force)) begin
            w_slot = c_SLOT_KB;
        end else if (bus.vga_req) begin
            w_slot = c_SLOT_VGA;
        end

        w_push = bus.kb_wr_valid && r_ready;
        w_pop  = (w_slot == c_SLOT_KB);

        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        // Only VGA grants taken while writes are waiting count toward starvation
        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = '0;
        end else if ((w_slot == c_SLOT_VGA) && (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + c_STV_W'(1);
        end
    end

    // Storage needs no reset: occupancy and pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.kb_wr_addr;
            r_fifo_data[r_wr_ptr] <= bus.kb_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
            r_gnt      <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            r_ready  <= (w_count_nxt != c_DEPTH);
            if (bus.kb_wr_valid && (r_count == c_DEPTH)) begin
                r_overflow <= 1'b1;
            end

            // BRAM samples the address on the falling edge, data is back here
            r_rvalid <= r_gnt;
            if (r_gnt) begin
                r_rdata <= bus.mem_q_b;
            end

            r_gnt <= (w_slot == c_SLOT_VGA);
            r_we  <= (w_slot == c_SLOT_KB);
            case (w_slot)
                c_SLOT_VGA: r_addr <= bus.vga_addr;
                c_SLOT_KB: begin
                    r_addr <= r_fifo_addr[r_rd_ptr];
                    r_data <= r_fifo_data[r_rd_ptr];
                end
                default: ;
            endcase
        end
    end

    assign bus.vga_gnt     = r_gnt;
    assign bus.vga_rdata   = r_rdata;
    assign bus.vga_rvalid  = r_rvalid;
    assign bus.kb_wr_ready = r_ready;
    assign bus.mem_addr_b  = r_addr;
    assign bus.mem_data_b  = r_data;
    assign bus.mem_we_b    = r_we;
    assign bus.fifo_count  = r_count;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bram_portb_arbiter.sv
// ============================================================================
// Module  : tb_bram_portb_arbiter
// Brief   : Self-checking bench against a queue-based behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bram_portb_arbiter;
    localparam int WIDTH        = 16;
    localparam int ADDR_WIDTH   = 10;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    bram_portb_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    bram_portb_arbiter #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // BRAM port b, clocked on the falling edge
    bit [WIDTH-1:0]      bram [1 << ADDR_WIDTH];
    logic                pre_en = 1'b0;
    logic [ADDR_WIDTH-1:0] pre_addr = '0;
    logic [WIDTH-1:0]    pre_data = '0;

    always @(negedge clk) begin
        if (pre_en) bram[pre_addr] <= pre_data;
        else if (bus.mem_we_b) bram[bus.mem_addr_b] <= bus.mem_data_b;
        bus.mem_q_b <= bram[bus.mem_addr_b];
    end

    // Behavioural model
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [WIDTH-1:0]      d;
    } wr_t;

    wr_t                   q[$];
    bit [WIDTH-1:0]        mmem [1 << ADDR_WIDTH];
    int                    starve;
    logic                  exp_gnt, exp_rvalid, exp_we, exp_ready, exp_ovf;
    logic [WIDTH-1:0]      exp_rdata, exp_data, pend_rd;
    logic [ADDR_WIDTH-1:0] exp_addr;

    task automatic model_reset();
        q.delete();
        starve     = 0;
        exp_gnt    = 0; exp_rvalid = 0; exp_we = 0; exp_ready = 0; exp_ovf = 0;
        exp_rdata  = '0; exp_data = '0; exp_addr = '0; pend_rd = '0;
    endtask

    task automatic model_edge();
        wr_t  e;
        logic was_full;
        logic push_ok;
        was_full   = (q.size() == FIFO_DEPTH);
        push_ok    = bus.kb_wr_valid && exp_ready;
        exp_rvalid = exp_gnt;
        if (exp_gnt) exp_rdata = pend_rd;
        exp_gnt = 0;
        exp_we  = 0;
        if (q.size() > 0 && (!bus.vga_req || starve == STARVE_LIMIT)) begin
            e = q.pop_front();
            exp_we   = 1;
            exp_addr = e.a;
            exp_data = e.d;
            mmem[e.a] = e.d;
            starve   = 0;
        end else if (bus.vga_req) begin
            exp_gnt  = 1;
            exp_addr = bus.vga_addr;
            pend_rd  = mmem[bus.vga_addr];
            if (q.size() > 0) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
            else starve = 0;
        end else begin
            starve = 0;
        end
        if (push_ok) q.push_back({bus.kb_wr_addr, bus.kb_wr_data});
        if (bus.kb_wr_valid && was_full) exp_ovf = 1;
        exp_ready = (q.size() != FIFO_DEPTH);
    endtask

    function automatic logic [49:0] exp_vec();
        return {exp_gnt, exp_rvalid, exp_rdata, exp_we, exp_addr, exp_data,
                exp_ready, 3'(q.size()), exp_ovf};
    endfunction

    function automatic logic [49:0] dut_vec();
        return {bus.vga_gnt, bus.vga_rvalid, bus.vga_rdata, bus.mem_we_b, bus.mem_addr_b,
                bus.mem_data_b, bus.kb_wr_ready, bus.fifo_count, bus.overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.vga_req = 0; bus.vga_addr = '0;
        bus.kb_wr_valid = 0; bus.kb_wr_addr = '0; bus.kb_wr_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 0;
        #4;
        checks++;
        if (dut_vec() !== 50'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        checks++;
        if (bus.kb_wr_ready !== 1'b0) begin
            failures++; $display("FAIL ready_before_edge: got %b expected 0", bus.kb_wr_ready);
        end
        tick();
        checks++;
        if (bus.kb_wr_ready !== 1'b1 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL ready_after_edge: got ready=%b count=%0d expected ready=1 count=0",
                     bus.kb_wr_ready, bus.fifo_count);
        end
    endtask

    task automatic test_vga_read();
        pre_addr = 10'h010; pre_data = 16'hBEEF; pre_en = 1;
        @(negedge clk);
        #1 pre_en = 0;
        mmem[10'h010] = 16'hBEEF;
        bus.vga_req = 1; bus.vga_addr = 10'h010;
        tick();
        checks++;
        if (bus.vga_gnt !== 1 || bus.mem_addr_b !== 10'h010 || bus.mem_we_b !== 0) begin
            failures++;
            $display("FAIL vga_grant: got gnt=%b addr=%h we=%b expected gnt=1 addr=010 we=0",
                     bus.vga_gnt, bus.mem_addr_b, bus.mem_we_b);
        end
        bus.vga_req = 0;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1 || bus.vga_rdata !== 16'hBEEF || bus.vga_gnt !== 0) begin
            failures++;
            $display("FAIL vga_rdata: got rvalid=%b rdata=%h gnt=%b expected 1 BEEF 0",
                     bus.vga_rvalid, bus.vga_rdata, bus.vga_gnt);
        end
    endtask

    task automatic test_kb_writes();
        bus.vga_req = 0;
        bus.kb_wr_valid = 1; bus.kb_wr_addr = 10'h300; bus.kb_wr_data = 16'h0041;
        tick();
        checks++;
        if (bus.fifo_count !== 3'd1 || bus.mem_we_b !== 0) begin
            failures++; $display("FAIL kb_push1: got count=%0d we=%b expected 1 0",
                                 bus.fifo_count, bus.mem_we_b);
        end
        bus.kb_wr_addr = 10'h301; bus.kb_wr_data = 16'h0042;
        tick();
        bus.kb_wr_valid = 0;
        checks++;
        if (bus.mem_we_b !== 1 || bus.mem_addr_b !== 10'h300 || bus.mem_data_b !== 16'h0041) begin
            failures++; $display("FAIL kb_write1: got we=%b addr=%h data=%h expected 1 300 0041",
                                 bus.mem_we_b, bus.mem_addr_b, bus.mem_data_b);
        end
        tick();
        checks++;
        if (bus.mem_we_b !== 1 || bus.mem_addr_b !== 10'h301 || bus.mem_data_b !== 16'h0042 ||
            bus.fifo_count !== 3'd0) begin
            failures++; $display("FAIL kb_write2: got we=%b addr=%h data=%h count=%0d expected 1 301 0042 0",
                                 bus.mem_we_b, bus.mem_addr_b, bus.mem_data_b, bus.fifo_count);
        end
        tick();
        bus.vga_req = 1; bus.vga_addr = 10'h300;
        tick();
        bus.vga_addr = 10'h301;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1 || bus.vga_rdata !== 16'h0041) begin
            failures++; $display("FAIL kb_readback1: got rvalid=%b rdata=%h expected 1 0041",
                                 bus.vga_rvalid, bus.vga_rdata);
        end
        bus.vga_req = 0;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1 || bus.vga_rdata !== 16'h0042) begin
            failures++; $display("FAIL kb_readback2: got rvalid=%b rdata=%h expected 1 0042",
                                 bus.vga_rvalid, bus.vga_rdata);
        end
    endtask

    task automatic test_starvation();
        int grants = 0;
        bit seen = 0;
        bus.vga_req = 1; bus.vga_addr = 10'(($urandom % 32));
        bus.kb_wr_valid = 1; bus.kb_wr_addr = 10'h200; bus.kb_wr_data = 16'hA5C3;
        tick();
        bus.kb_wr_valid = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.vga_addr = 10'(($urandom % 32));
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL starve_cycle: got %h expected %h", dut_vec(), exp_vec());
            end
            if (bus.mem_we_b) begin
                seen = 1;
                checks++;
                if (bus.vga_gnt !== 0 || bus.mem_addr_b !== 10'h200 || bus.mem_data_b !== 16'hA5C3) begin
                    failures++; $display("FAIL starve_write: got gnt=%b addr=%h data=%h expected 0 200 A5C3",
                                         bus.vga_gnt, bus.mem_addr_b, bus.mem_data_b);
                end
            end else if (bus.vga_gnt) begin
                grants++;
            end
        end
        checks++;
        if (!seen || grants != STARVE_LIMIT) begin
            failures++; $display("FAIL starve_grants: got seen=%0d grants=%0d expected 1 %0d",
                                 seen, grants, STARVE_LIMIT);
        end
        tick();
        checks++;
        if (bus.vga_gnt !== 1) begin
            failures++; $display("FAIL starve_resume: got gnt=%b expected 1", bus.vga_gnt);
        end
        bus.vga_req = 0;
        tick();
        checks++;
        if (bram[10'h200] !== 16'hA5C3) begin
            failures++; $display("FAIL starve_landed: got %h expected A5C3", bram[10'h200]);
        end
    endtask

    task automatic test_overflow();
        int idx = 0;
        bus.vga_req = 1; bus.vga_addr = 10'h005;
        for (int i = 0; i < 5; i++) begin
            bus.kb_wr_valid = 1; bus.kb_wr_addr = 10'(10'h100 + i); bus.kb_wr_data = 16'(16'h1000 + i);
            tick();
            if (i == 3) begin
                checks++;
                if (bus.kb_wr_ready !== 0) begin
                    failures++; $display("FAIL ovf_ready: got %b expected 0", bus.kb_wr_ready);
                end
            end
        end
        bus.kb_wr_valid = 0;
        checks++;
        if (bus.overflow !== 1 || bus.fifo_count !== 3'd4 || bus.kb_wr_ready !== 0) begin
            failures++; $display("FAIL ovf_state: got ovf=%b count=%0d ready=%b expected 1 4 0",
                                 bus.overflow, bus.fifo_count, bus.kb_wr_ready);
        end
        bus.vga_req = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL ovf_drain: got %h expected %h", dut_vec(), exp_vec());
            end
            if (bus.mem_we_b) begin
                checks++;
                if (bus.mem_addr_b !== 10'(10'h100 + idx)) begin
                    failures++; $display("FAIL ovf_order: got %h expected %h",
                                         bus.mem_addr_b, 10'(10'h100 + idx));
                end
                idx++;
            end
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || idx != 4) begin
            failures++; $display("FAIL ovf_drained: got count=%0d writes=%0d expected 0 4",
                                 bus.fifo_count, idx);
        end
    endtask

    task automatic test_reset_midstream();
        bus.vga_req = 1; bus.vga_addr = 10'h010;
        for (int i = 0; i < 3; i++) begin
            bus.kb_wr_valid = 1; bus.kb_wr_addr = 10'(10'h040 + i); bus.kb_wr_data = 16'(16'h7700 + i);
            tick();
        end
        bus.kb_wr_valid = 0;
        checks++;
        if (bus.fifo_count !== 3'd3 || bus.vga_gnt !== 1) begin
            failures++; $display("FAIL mid_setup: got count=%0d gnt=%b expected 3 1",
                                 bus.fifo_count, bus.vga_gnt);
        end
        rst_n = 0;
        #1;
        checks++;
        if (dut_vec() !== 50'd0) begin
            failures++; $display("FAIL mid_reset_outputs: got %h expected 0", dut_vec());
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.vga_rvalid !== 0) begin
                failures++; $display("FAIL mid_rvalid_held: got %b expected 0", bus.vga_rvalid);
            end
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.vga_rvalid !== 0 || dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL mid_after: got %h expected %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.vga_req     = ($urandom_range(0, 99) < 60);
            bus.vga_addr    = 10'($urandom_range(0, 31));
            bus.kb_wr_valid = ($urandom_range(0, 99) < 50);
            bus.kb_wr_addr  = 10'($urandom_range(0, 31));
            bus.kb_wr_data  = 16'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_vga_read();
        test_kb_writes();
        test_starvation();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
